clock_set_ctrl: RTL and testbench

CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

---
 rtl/clock_set_ctrl_if.sv | 13 +
 rtl/clock_set_ctrl.sv | 71 +++++++
 tb/tb_clock_set_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: tick/button inputs and time/mode/blink outputs; master = stimulus side, slave = clock_set_ctrl
interface clock_set_ctrl_if;
  logic       tick_1hz;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [1:0] mode;
  logic       blink;
  modport master (output tick_1hz, btn_mode, btn_inc, input sec, min, hour, mode, blink);
  modport slave  (input tick_1hz, btn_mode, btn_inc, output sec, min, hour, mode, blink);
endinterface

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: HH:MM:SS clock with button set mode (ports: inclk, rst active-low async, bus slave = tick/buttons in, time/mode/blink out)
module clock_set_ctrl #(
  parameter int HOUR_MAX = 23
) (
  input  logic              inclk,
  input  logic              rst,
  clock_set_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10} state_t;
  state_t     r_state, w_state_n;
  logic [5:0] r_sec, r_min, w_sec_n, w_min_n, w_sec_inc, w_min_inc;
  logic [4:0] r_hour, w_hour_n, w_hour_inc;
  logic       r_blink, w_blink_n, r_mode_q, r_inc_q, w_mode_p, w_inc_p, w_tick;
  always_ff @(posedge inclk or negedge rst)
    if (!rst) begin
      r_state  <= RUN;
      r_sec    <= '0;
      r_min    <= '0;
      r_hour   <= '0;
      r_blink  <= 1'b0;
      r_mode_q <= 1'b0;
      r_inc_q  <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_sec    <= w_sec_n;
      r_min    <= w_min_n;
      r_hour   <= w_hour_n;
      r_blink  <= w_blink_n;
      r_mode_q <= bus.btn_mode;
      r_inc_q  <= bus.btn_inc;
    end
  // Out-of-range values load 0 on increment; an inc press coinciding with a mode press is dropped.
  always_comb begin
    w_tick     = bus.tick_1hz;
    w_mode_p   = bus.btn_mode & ~r_mode_q;
    w_inc_p    = bus.btn_inc & ~r_inc_q & ~w_mode_p;
    w_sec_inc  = (r_sec >= 6'd59) ? '0 : r_sec + 6'd1;
    w_min_inc  = (r_min >= 6'd59) ? '0 : r_min + 6'd1;
    w_hour_inc = (r_hour >= 5'(HOUR_MAX)) ? '0 : r_hour + 5'd1;
    w_state_n  = r_state;
    w_sec_n    = r_sec;
    w_min_n    = r_min;
    w_hour_n   = r_hour;
    w_blink_n  = 1'b0;
    case (r_state)
      RUN: begin
        w_state_n = w_mode_p ? SET_HOUR : RUN;
        w_sec_n   = w_tick ? w_sec_inc : r_sec;
        w_min_n   = (w_tick && r_sec == 6'd59) ? w_min_inc : r_min;
        w_hour_n  = (w_tick && r_sec == 6'd59 && r_min == 6'd59) ? w_hour_inc : r_hour;
      end
      SET_HOUR: begin
        w_state_n = w_mode_p ? SET_MIN : SET_HOUR;
        w_hour_n  = w_inc_p ? w_hour_inc : r_hour;
        w_blink_n = w_mode_p ? 1'b0 : r_blink ^ w_tick;
      end
      SET_MIN: begin
        w_state_n = w_mode_p ? RUN : SET_MIN;
        w_min_n   = w_inc_p ? w_min_inc : r_min;
        w_sec_n   = w_mode_p ? '0 : r_sec;
        w_blink_n = w_mode_p ? 1'b0 : r_blink ^ w_tick;
      end
      default: w_state_n = RUN;
    endcase
  end
  assign bus.sec   = r_sec;
  assign bus.min   = r_min;
  assign bus.hour  = r_hour;
  assign bus.mode  = r_state;
  assign bus.blink = r_blink;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed self-checking bench for clock_set_ctrl
module tb_clock_set_ctrl;
  logic inclk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  clock_set_ctrl_if bus();
  clock_set_ctrl #(.HOUR_MAX(23)) dut (.inclk(inclk), .rst(rst), .bus(bus));
  always #5 inclk = ~inclk;

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic press_mode();
    bus.btn_mode = 1'b1; step();
    bus.btn_mode = 1'b0; step();
  endtask

  task automatic inc_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_inc = 1'b1; step();
      bus.btn_inc = 1'b0; step();
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_1hz = 1'b1; step();
      bus.tick_1hz = 1'b0;
    end
    step();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.sec !== 6'd0) begin failures++; $display("FAIL reset_sec got=%0d exp=0", bus.sec); end
    checks++; if (bus.min !== 6'd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", bus.min); end
    checks++; if (bus.hour !== 5'd0) begin failures++; $display("FAIL reset_hour got=%0d exp=0", bus.hour); end
    checks++; if (bus.mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", bus.mode); end
    checks++; if (bus.blink !== 1'b0) begin failures++; $display("FAIL reset_blink got=%0d exp=0", bus.blink); end
    #5 rst = 1'b1;
    step();
  endtask

  task automatic test_carry();
    press_mode();
    checks++; if (bus.mode !== 2'd1) begin failures++; $display("FAIL carry_mode_sethour got=%0d exp=1", bus.mode); end
    inc_n(23);
    checks++; if (bus.hour !== 5'd23) begin failures++; $display("FAIL carry_hour23 got=%0d exp=23", bus.hour); end
    press_mode();
    checks++; if (bus.mode !== 2'd2) begin failures++; $display("FAIL carry_mode_setmin got=%0d exp=2", bus.mode); end
    inc_n(59);
    checks++; if (bus.min !== 6'd59) begin failures++; $display("FAIL carry_min59 got=%0d exp=59", bus.min); end
    press_mode();
    tick_n(59);
    checks++; if ({bus.hour, bus.min, bus.sec} !== {5'd23, 6'd59, 6'd59}) begin failures++; $display("FAIL carry_235959 got=%0d:%0d:%0d exp=23:59:59", bus.hour, bus.min, bus.sec); end
    tick_n(1);
    checks++; if ({bus.hour, bus.min, bus.sec, bus.mode} !== {5'd0, 6'd0, 6'd0, 2'd0}) begin failures++; $display("FAIL carry_wrap got=%0d:%0d:%0d mode=%0d exp=0:0:0 mode=0", bus.hour, bus.min, bus.sec, bus.mode); end
  endtask

  task automatic test_run_ignores_inc();
    inc_n(1);
    checks++; if ({bus.hour, bus.min, bus.sec, bus.mode} !== '0) begin failures++; $display("FAIL run_inc got=%0d:%0d:%0d mode=%0d exp=0:0:0 mode=0", bus.hour, bus.min, bus.sec, bus.mode); end
  endtask

  task automatic test_set_hours();
    logic [4:0] exp_h [3] = '{5'd23, 5'd0, 5'd1};
    tick_n(5);
    checks++; if (bus.sec !== 6'd5) begin failures++; $display("FAIL sethour_presec got=%0d exp=5", bus.sec); end
    press_mode();
    inc_n(22);
    checks++; if (bus.hour !== 5'd22) begin failures++; $display("FAIL sethour_22 got=%0d exp=22", bus.hour); end
    for (int i = 0; i < 3; i++) begin
      inc_n(1);
      checks++; if ({bus.hour, bus.min, bus.sec} !== {exp_h[i], 6'd0, 6'd5}) begin failures++; $display("FAIL sethour_inc%0d got=%0d:%0d:%0d exp=%0d:0:5", i, bus.hour, bus.min, bus.sec, exp_h[i]); end
    end
    tick_n(1);
    checks++; if ({bus.blink, bus.sec} !== {1'b1, 6'd5}) begin failures++; $display("FAIL sethour_tick1 got=blink%0d sec%0d exp=blink1 sec5", bus.blink, bus.sec); end
    tick_n(1);
    checks++; if ({bus.blink, bus.sec} !== {1'b0, 6'd5}) begin failures++; $display("FAIL sethour_tick2 got=blink%0d sec%0d exp=blink0 sec5", bus.blink, bus.sec); end
    tick_n(1);
    press_mode();
    checks++; if ({bus.mode, bus.blink} !== {2'd2, 1'b0}) begin failures++; $display("FAIL sethour_exit got=mode%0d blink%0d exp=mode2 blink0", bus.mode, bus.blink); end
    press_mode();
    checks++; if ({bus.mode, bus.sec, bus.hour} !== {2'd0, 6'd0, 5'd1}) begin failures++; $display("FAIL sethour_run got=mode%0d sec%0d hour%0d exp=mode0 sec0 hour1", bus.mode, bus.sec, bus.hour); end
  endtask

  task automatic test_set_min();
    tick_n(3);
    press_mode(); press_mode();
    checks++; if ({bus.mode, bus.sec} !== {2'd2, 6'd3}) begin failures++; $display("FAIL setmin_enter got=mode%0d sec%0d exp=mode2 sec3", bus.mode, bus.sec); end
    inc_n(59);
    checks++; if (bus.min !== 6'd59) begin failures++; $display("FAIL setmin_59 got=%0d exp=59", bus.min); end
    inc_n(1);
    checks++; if ({bus.min, bus.hour, bus.sec} !== {6'd0, 5'd1, 6'd3}) begin failures++; $display("FAIL setmin_wrap got=min%0d hour%0d sec%0d exp=min0 hour1 sec3", bus.min, bus.hour, bus.sec); end
    press_mode();
    checks++; if ({bus.mode, bus.sec} !== {2'd0, 6'd0}) begin failures++; $display("FAIL setmin_exit got=mode%0d sec%0d exp=mode0 sec0", bus.mode, bus.sec); end
  endtask

  task automatic test_collision();
    press_mode();
    bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; step();
    checks++; if ({bus.mode, bus.hour} !== {2'd2, 5'd1}) begin failures++; $display("FAIL coll_modeinc got=mode%0d hour%0d exp=mode2 hour1", bus.mode, bus.hour); end
    bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; step();
    press_mode();
    bus.tick_1hz = 1'b1; bus.btn_mode = 1'b1; step();
    checks++; if ({bus.mode, bus.sec} !== {2'd1, 6'd1}) begin failures++; $display("FAIL coll_tickmode got=mode%0d sec%0d exp=mode1 sec1", bus.mode, bus.sec); end
    bus.tick_1hz = 1'b0; bus.btn_mode = 1'b0; step();
    press_mode(); press_mode();
  endtask

  task automatic test_held_button();
    press_mode(); press_mode();
    bus.btn_inc = 1'b1;
    repeat (10) step();
    bus.btn_inc = 1'b0; step();
    checks++; if (bus.min !== 6'd1) begin failures++; $display("FAIL held_inc got=%0d exp=1", bus.min); end
    press_mode();
  endtask

  task automatic test_async_reset();
    #2 rst = 1'b0;
    #1 rst = 1'b1;
    press_mode(); inc_n(12);
    press_mode(); inc_n(34);
    press_mode(); tick_n(56);
    press_mode(); press_mode();
    tick_n(1);
    checks++; if ({bus.hour, bus.min, bus.sec, bus.mode, bus.blink} !== {5'd12, 6'd34, 6'd56, 2'd2, 1'b1}) begin failures++; $display("FAIL async_pre got=%0d:%0d:%0d mode%0d blink%0d exp=12:34:56 mode2 blink1", bus.hour, bus.min, bus.sec, bus.mode, bus.blink); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.hour, bus.min, bus.sec, bus.mode, bus.blink} !== '0) begin failures++; $display("FAIL async_clear got=%0d:%0d:%0d mode%0d blink%0d exp=0:0:0 mode0 blink0", bus.hour, bus.min, bus.sec, bus.mode, bus.blink); end
    bus.btn_mode = 1'b1;
    #1 rst = 1'b1;
    step();
    checks++; if (bus.mode !== 2'd1) begin failures++; $display("FAIL release_held_press got=%0d exp=1", bus.mode); end
    repeat (3) step();
    bus.btn_mode = 1'b0; step();
    checks++; if (bus.mode !== 2'd1) begin failures++; $display("FAIL release_held_once got=%0d exp=1", bus.mode); end
  endtask

  initial begin
    bus.tick_1hz = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b0;
    test_reset();
    test_carry();
    test_run_ignores_inc();
    test_set_hours();
    test_set_min();
    test_collision();
    test_held_button();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
